// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the NTT-domain pointwise product path.
// The gamma table is generated at elaboration from the pair index and q.
package poly_arith_pkg;

  localparam int unsigned Q            = 3329;
  localparam int unsigned MONT_R_LOG2  = 16;
  localparam int unsigned N_COEFFS_DEF = 256;
  localparam int unsigned COEFF_BITS   = 16;

  typedef logic [COEFF_BITS-1:0] coeff_t;

  typedef struct packed {
    coeff_t c0;
    coeff_t c1;
  } pair_t;

  function automatic int unsigned bitrev7(input int unsigned i);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < 7; b++) begin
      r = (r << 1) | ((i >> b) & 1);
    end
    return r;
  endfunction

  // gamma_i = 17^(2*BitRev7(i)+1) mod q, lifted into the Montgomery domain.
  function automatic coeff_t gamma_mont(input int unsigned i);
    int unsigned e;
    int unsigned g;
    e = 2 * bitrev7(i) + 1;
    g = 1;
    for (int unsigned n = 0; n < e; n++) begin
      g = (g * 17) % Q;
    end
    return coeff_t'((g << MONT_R_LOG2) % Q);
  endfunction

  localparam coeff_t BCM_GAMMA_MONT [0:127] = '{
    gamma_mont(0),   gamma_mont(1),   gamma_mont(2),   gamma_mont(3),
    gamma_mont(4),   gamma_mont(5),   gamma_mont(6),   gamma_mont(7),
    gamma_mont(8),   gamma_mont(9),   gamma_mont(10),  gamma_mont(11),
    gamma_mont(12),  gamma_mont(13),  gamma_mont(14),  gamma_mont(15),
    gamma_mont(16),  gamma_mont(17),  gamma_mont(18),  gamma_mont(19),
    gamma_mont(20),  gamma_mont(21),  gamma_mont(22),  gamma_mont(23),
    gamma_mont(24),  gamma_mont(25),  gamma_mont(26),  gamma_mont(27),
    gamma_mont(28),  gamma_mont(29),  gamma_mont(30),  gamma_mont(31),
    gamma_mont(32),  gamma_mont(33),  gamma_mont(34),  gamma_mont(35),
    gamma_mont(36),  gamma_mont(37),  gamma_mont(38),  gamma_mont(39),
    gamma_mont(40),  gamma_mont(41),  gamma_mont(42),  gamma_mont(43),
    gamma_mont(44),  gamma_mont(45),  gamma_mont(46),  gamma_mont(47),
    gamma_mont(48),  gamma_mont(49),  gamma_mont(50),  gamma_mont(51),
    gamma_mont(52),  gamma_mont(53),  gamma_mont(54),  gamma_mont(55),
    gamma_mont(56),  gamma_mont(57),  gamma_mont(58),  gamma_mont(59),
    gamma_mont(60),  gamma_mont(61),  gamma_mont(62),  gamma_mont(63),
    gamma_mont(64),  gamma_mont(65),  gamma_mont(66),  gamma_mont(67),
    gamma_mont(68),  gamma_mont(69),  gamma_mont(70),  gamma_mont(71),
    gamma_mont(72),  gamma_mont(73),  gamma_mont(74),  gamma_mont(75),
    gamma_mont(76),  gamma_mont(77),  gamma_mont(78),  gamma_mont(79),
    gamma_mont(80),  gamma_mont(81),  gamma_mont(82),  gamma_mont(83),
    gamma_mont(84),  gamma_mont(85),  gamma_mont(86),  gamma_mont(87),
    gamma_mont(88),  gamma_mont(89),  gamma_mont(90),  gamma_mont(91),
    gamma_mont(92),  gamma_mont(93),  gamma_mont(94),  gamma_mont(95),
    gamma_mont(96),  gamma_mont(97),  gamma_mont(98),  gamma_mont(99),
    gamma_mont(100), gamma_mont(101), gamma_mont(102), gamma_mont(103),
    gamma_mont(104), gamma_mont(105), gamma_mont(106), gamma_mont(107),
    gamma_mont(108), gamma_mont(109), gamma_mont(110), gamma_mont(111),
    gamma_mont(112), gamma_mont(113), gamma_mont(114), gamma_mont(115),
    gamma_mont(116), gamma_mont(117), gamma_mont(118), gamma_mont(119),
    gamma_mont(120), gamma_mont(121), gamma_mont(122), gamma_mont(123),
    gamma_mont(124), gamma_mont(125), gamma_mont(126), gamma_mont(127)
  };

endpackage

// File: rtl/base_case_mul.sv
// Degree-one base-case product (c0,c1) = (a0+a1X)(b0+b1X) mod (X^2-zeta), times R^-1.
// Signed Montgomery arithmetic; outputs are representatives in (-2q,2q).
module base_case_mul
  import poly_arith_pkg::*;
(
  input  coeff_t a0,
  input  coeff_t a1,
  input  coeff_t b0,
  input  coeff_t b1,
  input  coeff_t zeta,
  output coeff_t c0,
  output coeff_t c1
);

  localparam logic signed [31:0] QINV = -32'sd3327;
  localparam logic signed [31:0] QS   = 32'sd3329;

  function automatic logic signed [15:0] mont_reduce(input logic signed [31:0] x);
    logic signed [15:0] t;
    logic signed [31:0] tw;
    logic signed [31:0] r;
    t  = 16'(x * QINV);
    tw = t;
    r  = x - tw * QS;
    return 16'(r >>> 16);
  endfunction

  logic signed [31:0] sa0, sa1, sb0, sb1, sz;
  logic signed [15:0] m00, m11, mz, m01;

  always_comb begin
    sa0 = 32'($signed(a0));
    sa1 = 32'($signed(a1));
    sb0 = 32'($signed(b0));
    sb1 = 32'($signed(b1));
    sz  = 32'($signed(zeta));
    m00 = mont_reduce(sa0 * sb0);
    m11 = mont_reduce(sa1 * sb1);
    mz  = mont_reduce(32'(m11) * sz);
    m01 = mont_reduce(sa0 * sb1 + sa1 * sb0);
    c0  = coeff_t'(m00 + mz);
    c1  = coeff_t'(m01);
  end

endmodule

// File: rtl/bcm_stream_engine_rom.sv
// Pair-index to Montgomery-domain gamma lookup, purely combinational.
module bcm_zeta_rom
  import poly_arith_pkg::*;
(
  input  logic [6:0] idx,
  output coeff_t     zeta
);

  always_comb zeta = BCM_GAMMA_MONT[idx];

endmodule

// File: rtl/bcm_stream_engine.sv
// Streams A,B coefficient beats into base-case pairs and serialises the
// (c0,c1) results back out one coefficient per beat.
module bcm_stream_engine
  import poly_arith_pkg::*;
#(
  parameter int unsigned N_COEFFS = N_COEFFS_DEF,
  parameter int unsigned COEFF_W  = COEFF_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [COEFF_W-1:0] a_i,
  input  logic [COEFF_W-1:0] b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [COEFF_W-1:0] c_o,
  output logic               out_last_o,
  output logic               busy_o
);

  localparam int unsigned KW = $clog2(N_COEFFS);

  logic [KW-1:0] k_cnt, j_cnt;
  coeff_t        a0_q, b0_q;
  logic          half_q, full_q, ph_q;
  pair_t         out_buf;

  logic          in_fire, out_fire;
  logic [6:0]    zeta_idx;
  coeff_t        zeta, c0_new, c1_new;

  always_comb begin
    zeta_idx    = 7'(k_cnt >> 1);
    // An odd beat may overwrite the buffer only if it is empty or its last word leaves now.
    in_ready_o  = !k_cnt[0] || !full_q || (ph_q && out_ready_i);
    in_fire     = in_valid_i && in_ready_o;
    out_valid_o = full_q;
    out_fire    = full_q && out_ready_i;
    c_o         = ph_q ? out_buf.c1 : out_buf.c0;
    out_last_o  = full_q && (j_cnt == KW'(N_COEFFS - 1));
    busy_o      = half_q || full_q;
  end

  bcm_zeta_rom u_rom (
    .idx  (zeta_idx),
    .zeta (zeta)
  );

  base_case_mul u_core (
    .a0   (a0_q),
    .a1   (a_i),
    .b0   (b0_q),
    .b1   (b_i),
    .zeta (zeta),
    .c0   (c0_new),
    .c1   (c1_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_cnt   <= '0;
      j_cnt   <= '0;
      a0_q    <= '0;
      b0_q    <= '0;
      half_q  <= 1'b0;
      full_q  <= 1'b0;
      ph_q    <= 1'b0;
      out_buf <= '0;
    end else begin
      if (out_fire) begin
        ph_q  <= ~ph_q;
        j_cnt <= j_cnt + KW'(1);
        if (ph_q) full_q <= 1'b0;
      end
      // Placed after the drain logic so a same-edge refill overrides full_q/ph_q.
      if (in_fire) begin
        k_cnt <= k_cnt + KW'(1);
        if (!k_cnt[0]) begin
          a0_q   <= a_i;
          b0_q   <= b_i;
          half_q <= 1'b1;
        end else begin
          out_buf <= '{c0: c0_new, c1: c1_new};
          full_q  <= 1'b1;
          half_q  <= 1'b0;
          ph_q    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcm_stream_engine.sv
// Directed and randomised checks of the pair-packing product stream, compared mod q.
module tb_bcm_stream_engine;

  localparam int Q = 3329;
  localparam int RINV = 169;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o, out_valid_o, out_ready_i, out_last_o, busy_o;
  logic [15:0] a_i, b_i, c_o;

  always #5 clk = ~clk;

  bcm_stream_engine #(.N_COEFFS(256), .COEFF_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .c_o         (c_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o)
  );

  typedef struct { int c; bit last; } exp_item_t;
  typedef struct { int a0; int a1; int b0; int b1; int e0; int e1; } vec_t;

  exp_item_t   exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int unsigned k_model = 0;
  int          beats_acc = 0;
  int          rdy_mode = 0;
  longint      cyc = 0;
  bit          b2b_en = 0;
  int          gaps = 0;
  longint      last_fire = -1;
  bit          stall_prev = 0;
  logic [15:0] c_prev;
  logic        last_prev;

  function automatic int modq(input longint x);
    longint r;
    r = x % Q;
    if (r < 0) r += Q;
    return int'(r);
  endfunction

  function automatic int gamma_of(input int i);
    int br, g;
    br = 0;
    for (int b = 0; b < 7; b++) br = (br << 1) | ((i >> b) & 1);
    g = 1;
    for (int n = 0; n < 2 * br + 1; n++) g = (g * 17) % Q;
    return g;
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = 1'($urandom_range(0, 1));
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (k_model % 2 == 0) check("even_ready", in_ready_o, 1);
      if (stall_prev) begin
        check("stall_valid", out_valid_o, 1);
        check("stall_c", c_o, c_prev);
        check("stall_last", out_last_o, last_prev);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", exp_q.size(), 1);
        end else begin
          exp_item_t e;
          e = exp_q.pop_front();
          check("c_o", modq(longint'($signed(c_o))), e.c);
          check("out_last", out_last_o, e.last);
        end
        if (b2b_en) begin
          if (last_fire >= 0 && cyc != last_fire + 1) gaps++;
          last_fire = cyc;
        end
      end
      stall_prev = out_valid_o && !out_ready_i;
      c_prev     = c_o;
      last_prev  = out_last_o;
    end
  end

  task automatic send_beat(input int a, input int b);
    bit ok;
    ok = 0;
    in_valid_i = 1'b1;
    a_i = 16'(a);
    b_i = 16'(b);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (in_ready_o) begin
        @(posedge clk);
        ok = 1;
        beats_acc++;
        k_model = (k_model + 1) % 256;
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL in_timeout: beat %0d not accepted within 1000 cycles", k_model);
    end
  endtask

  task automatic rand_gap(input bit en);
    if (en && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pair_exp(input int a0, input int a1, input int b0, input int b1,
                               input int e0, input int e1);
    int p;
    p = int'(k_model / 2);
    exp_q.push_back('{c: e0, last: 1'b0});
    exp_q.push_back('{c: e1, last: (p == 127)});
    send_beat(a0, b0);
    send_beat(a1, b1);
  endtask

  task automatic send_pair_model(input int a0, input int a1, input int b0, input int b1,
                                 input bit gap_en);
    int p;
    longint s0, s1;
    p  = int'(k_model / 2);
    s0 = longint'(a0) * b0 + longint'(modq(longint'(a1) * b1)) * gamma_of(p);
    s1 = longint'(a0) * b1 + longint'(a1) * b0;
    exp_q.push_back('{c: modq(longint'(modq(s0)) * RINV), last: 1'b0});
    exp_q.push_back('{c: modq(longint'(modq(s1)) * RINV), last: (p == 127)});
    rand_gap(gap_en);
    send_beat(a0, b0);
    rand_gap(gap_en);
    send_beat(a1, b1);
  endtask

  task automatic send_random_pairs(input int n, input bit gap_en);
    for (int i = 0; i < n; i++)
      send_pair_model($urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
                      $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), gap_en);
  endtask

  task automatic drain();
    for (int n = 0; n < 3000; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_c_o", c_o, 0);
    check("rst_out_last", out_last_o, 0);
    check("rst_busy", busy_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid_i = 1'b0;
    exp_q.delete();
    k_model = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[7];
    int   base, diff;

    tbl[0] = '{a0: 1,    a1: 0,    b0: 1,    b1: 0, e0: 169,  e1: 0};
    tbl[1] = '{a0: 0,    a1: 1,    b0: 0,    b1: 1, e0: 456,  e1: 0};
    tbl[2] = '{a0: 2,    a1: 0,    b0: 3,    b1: 0, e0: 1014, e1: 0};
    tbl[3] = '{a0: 0,    a1: 1,    b0: 1,    b1: 0, e0: 0,    e1: 169};
    tbl[4] = '{a0: 3,    a1: 0,    b0: 0,    b1: 5, e0: 0,    e1: 2535};
    tbl[5] = '{a0: 3328, a1: 0,    b0: 3328, b1: 0, e0: 169,  e1: 0};
    tbl[6] = '{a0: 10,   a1: 0,    b0: 100,  b1: 0, e0: 2550, e1: 0};

    rst = 1'b1;
    in_valid_i = 1'b0;
    a_i = '0;
    b_i = '0;
    #3;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++)
      send_pair_exp(tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, tbl[i].e0, tbl[i].e1);
    drain();
    check("idle_busy", busy_o, 0);

    do_reset();
    send_pair_exp(0, 1, 0, 1, 2873, 0);
    drain();
    send_beat(5, 7);
    @(negedge clk);
    check("half_busy", busy_o, 1);
    do_reset();
    #1;
    check("half_busy_cleared", busy_o, 0);

    // Two polynomials back to back with a permanently ready sink.
    b2b_en = 1;
    gaps = 0;
    last_fire = -1;
    send_random_pairs(256, 0);
    drain();
    b2b_en = 0;
    check("b2b_gaps", gaps, 0);

    // Sink stalls for 10 edges in the middle of a stream.
    fork
      send_random_pairs(64, 0);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        rdy_mode = 2;
        @(posedge clk);
        #3;
        base = beats_acc;
        repeat (10) @(posedge clk);
        #3;
        diff = beats_acc - base;
        compared++;
        if (diff > 3) begin
          mismatched++;
          $display("FAIL bp_accepts: got %0d accepted beats, required at most 3", diff);
        end
        @(negedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    // Reset with beat 101 just accepted and its pair waiting on the output.
    do_reset();
    send_random_pairs(51, 0);
    rdy_mode = 2;
    @(negedge clk);
    check("pre_rst_out_valid", out_valid_o, 1);
    rst = 1'b1;
    exp_q.delete();
    k_model = 0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send_pair_exp(0, 1, 0, 1, 2873, 0);
    drain();

    // Random valid/ready toggling over four polynomials.
    do_reset();
    rdy_mode = 1;
    send_random_pairs(512, 1);
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
